// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared board geometry, colour codes and FSM states for the Life scheduler
package life_pkg;

   localparam int ROWS = 12;
   localparam int COLS = 12;

   localparam logic [1:0] COL_DEAD     = 2'b00;
   localparam logic [1:0] COL_CUR_DEAD = 2'b01;
   localparam logic [1:0] COL_CUR_LIVE = 2'b10;
   localparam logic [1:0] COL_LIVE     = 2'b11;

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT, CLEAR} state_t;

   function automatic logic [1:0] cell_colour(input logic alive, input logic at_cursor);
      if (alive)
         return at_cursor ? COL_CUR_LIVE : COL_LIVE;
      else
         return at_cursor ? COL_CUR_DEAD : COL_DEAD;
   endfunction

endpackage

// File: rtl/life_cell_eval.sv
// rtl/life_cell_eval.sv - B3/S23 next-state for one cell from its eight neighbours
module life_cell_eval (
   input  logic [7:0] nbrs,
   input  logic       self_alive,
   output logic       next_alive
);

   logic [3:0] count;

   always_comb begin
      count = '0;
      for (int i = 0; i < 8; i++)
         count = count + {3'b000, nbrs[i]};
      next_alive = (count == 4'd3) || (self_alive && (count == 4'd2));
   end

endmodule

// File: rtl/life_scheduler.sv
// rtl/life_scheduler.sv - Game-of-Life board owner: edits, clear, one-cell-per-cycle generation scan
module life_scheduler #(
   parameter int ROWS     = life_pkg::ROWS,
   parameter int COLS     = life_pkg::COLS,
   parameter int TICK_DIV = 50_000_000,
   parameter int WRAP     = 1
) (
   input  logic                             clk,
   input  logic                             reset_btn,
   input  logic                             run_en,
   input  logic                             step_req,
   input  logic                             clear_req,
   input  logic                             edit_req,
   input  logic [3:0]                       cursor_row,
   input  logic [3:0]                       cursor_col,
   input  logic                             cursor_en,
   output logic [ROWS-1:0][COLS-1:0][1:0]   pixiv,
   output logic                             busy,
   output logic [15:0]                      generation,
   output logic                             gen_done
);

   import life_pkg::*;

   localparam logic [3:0]  R_LAST = 4'(ROWS - 1);
   localparam logic [3:0]  C_LAST = 4'(COLS - 1);
   localparam logic [31:0] T_LAST = 32'(TICK_DIV - 1);

   state_t                 state, state_nxt;
   logic [ROWS-1:0][COLS-1:0] cur, nxt;
   logic [3:0]             r, c;
   logic [31:0]            tick_cnt;
   logic                   tick_pend, clr_pend, tick_hit;
   logic                   cursor_ok, start_scan, do_edit;
   logic [3:0]             ru, rd, cl, cr;
   logic                   vu, vd, vl, vr;
   logic [7:0]             nbrs;
   logic                   cell_next;

   assign cursor_ok = ({1'b0, cursor_row} < 5'(ROWS)) && ({1'b0, cursor_col} < 5'(COLS));
   assign tick_hit  = run_en && (tick_cnt == T_LAST);
   assign busy      = (state == SCAN) || (state == COMMIT);
   assign gen_done  = (state == COMMIT);

   // Neighbour coordinates wrap; the valid flags mask off-board cells when WRAP is 0.
   always_comb begin
      ru = (r == 4'd0)   ? R_LAST : r - 4'd1;
      rd = (r == R_LAST) ? 4'd0   : r + 4'd1;
      cl = (c == 4'd0)   ? C_LAST : c - 4'd1;
      cr = (c == C_LAST) ? 4'd0   : c + 4'd1;
      vu = (WRAP != 0) || (r != 4'd0);
      vd = (WRAP != 0) || (r != R_LAST);
      vl = (WRAP != 0) || (c != 4'd0);
      vr = (WRAP != 0) || (c != C_LAST);
      nbrs[0] = vu & vl & cur[ru][cl];
      nbrs[1] = vu &      cur[ru][c];
      nbrs[2] = vu & vr & cur[ru][cr];
      nbrs[3] =      vl & cur[r][cl];
      nbrs[4] =      vr & cur[r][cr];
      nbrs[5] = vd & vl & cur[rd][cl];
      nbrs[6] = vd &      cur[rd][c];
      nbrs[7] = vd & vr & cur[rd][cr];
   end

   life_cell_eval u_eval (
      .nbrs       (nbrs),
      .self_alive (cur[r][c]),
      .next_alive (cell_next)
   );

   always_ff @(posedge clk or posedge reset_btn) begin
      if (reset_btn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      start_scan = 1'b0;
      do_edit    = 1'b0;
      case (state)
         IDLE: begin
            if (clear_req || clr_pend) begin
               state_nxt = CLEAR;
            end else if (edit_req) begin
               do_edit = cursor_ok;
            end else if (step_req || tick_pend) begin
               state_nxt  = SCAN;
               start_scan = 1'b1;
            end
         end
         SCAN:    if (r == R_LAST && c == C_LAST) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         CLEAR:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset_btn) begin
      if (reset_btn) begin
         cur        <= '0;
         nxt        <= '0;
         r          <= '0;
         c          <= '0;
         generation <= '0;
         tick_cnt   <= '0;
         tick_pend  <= 1'b0;
         clr_pend   <= 1'b0;
      end else begin
         if (!run_en || tick_cnt == T_LAST)
            tick_cnt <= '0;
         else
            tick_cnt <= tick_cnt + 32'd1;

         // A fresh tick beats the consume so a tick landing on the start cycle is not lost.
         if (tick_hit)
            tick_pend <= 1'b1;
         else if (start_scan)
            tick_pend <= 1'b0;

         if (state == CLEAR)
            clr_pend <= 1'b0;
         else if (busy && clear_req)
            clr_pend <= 1'b1;

         if (do_edit)
            cur[cursor_row][cursor_col] <= ~cur[cursor_row][cursor_col];

         if (start_scan) begin
            r <= '0;
            c <= '0;
         end

         if (state == SCAN) begin
            nxt[r][c] <= cell_next;
            if (c == C_LAST) begin
               c <= '0;
               r <= (r == R_LAST) ? 4'd0 : r + 4'd1;
            end else begin
               c <= c + 4'd1;
            end
         end

         if (state == COMMIT) begin
            cur        <= nxt;
            generation <= generation + 16'd1;
         end

         if (state == CLEAR) begin
            cur        <= '0;
            generation <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset_btn) begin
      if (reset_btn) begin
         pixiv <= '0;
      end else begin
         for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
               pixiv[i][j] <= cell_colour(cur[i][j],
                  cursor_en && cursor_ok && (cursor_row == 4'(i)) && (cursor_col == 4'(j)));
      end
   end

endmodule

// File: tb/tb_life_scheduler.sv
// tb/tb_life_scheduler.sv - directed vector bench for life_scheduler (wrap and no-wrap instances)
module tb_life_scheduler;

   typedef struct {
      bit           keep;
      bit           wrap;
      logic [143:0] init;
      logic [143:0] exp;
      logic [15:0]  gen;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_btn = 1'b1;
   logic        run_en = 1'b0, step_req = 1'b0, clear_req = 1'b0, edit_req = 1'b0;
   logic        cursor_en = 1'b0;
   logic [3:0]  cursor_row = 4'd0, cursor_col = 4'd0;
   logic [287:0] pix_w, pix_nw;
   logic        busy_w, busy_nw, gd_w, gd_nw;
   logic [15:0] gen_w, gen_nw;

   int tests = 0;
   int fails = 0;
   vec_t vecs[8];
   logic [143:0] bh, bv, corners;
   int n;

   always #5 clk = ~clk;

   life_scheduler #(.TICK_DIV(10), .WRAP(1)) u_dut (
      .clk(clk), .reset_btn(reset_btn), .run_en(run_en), .step_req(step_req),
      .clear_req(clear_req), .edit_req(edit_req), .cursor_row(cursor_row),
      .cursor_col(cursor_col), .cursor_en(cursor_en), .pixiv(pix_w),
      .busy(busy_w), .generation(gen_w), .gen_done(gd_w)
   );

   life_scheduler #(.TICK_DIV(10), .WRAP(0)) u_dut_nw (
      .clk(clk), .reset_btn(reset_btn), .run_en(run_en), .step_req(step_req),
      .clear_req(clear_req), .edit_req(edit_req), .cursor_row(cursor_row),
      .cursor_col(cursor_col), .cursor_en(cursor_en), .pixiv(pix_nw),
      .busy(busy_nw), .generation(gen_nw), .gen_done(gd_nw)
   );

   function automatic logic [143:0] at(input int r, input int c);
      logic [143:0] b;
      b = '0;
      b[r*12 + c] = 1'b1;
      return b;
   endfunction

   function automatic logic [287:0] to_pix(input logic [143:0] b);
      logic [287:0] p;
      p = '0;
      for (int i = 0; i < 144; i++)
         if (b[i]) p[2*i +: 2] = 2'b11;
      return p;
   endfunction

   function automatic vec_t mk(input bit k, input bit w, input logic [143:0] i,
                               input logic [143:0] e, input logic [15:0] g);
      vec_t v;
      v.keep = k; v.wrap = w; v.init = i; v.exp = e; v.gen = g;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic clear_board();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      tick();
      tick();
   endtask

   task automatic load(input logic [143:0] b);
      for (int r = 0; r < 12; r++)
         for (int c = 0; c < 12; c++)
            if (b[r*12 + c]) begin
               cursor_row = 4'(r);
               cursor_col = 4'(c);
               edit_req   = 1'b1;
               tick();
            end
      edit_req = 1'b0;
      tick();
      tick();
   endtask

   task automatic wait_gen(input int budget, output int cnt);
      cnt = 0;
      while (!gd_w && cnt < budget) begin
         tick();
         cnt++;
      end
   endtask

   task automatic step(output int lat);
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      wait_gen(400, lat);
      lat++;
   endtask

   task automatic no_gen(input string name, input int cycles);
      int seen;
      seen = 0;
      repeat (cycles) begin
         tick();
         if (gd_w) seen++;
      end
      check(name, 288'(seen), 288'd0);
   endtask

   initial begin
      bh      = at(5,4) | at(5,5) | at(5,6);
      bv      = at(4,5) | at(5,5) | at(6,5);
      corners = at(0,0) | at(0,11) | at(11,0) | at(11,11);
      vecs[0] = mk(0, 1, bh, bv, 16'd1);
      vecs[1] = mk(1, 1, '0, bh, 16'd2);
      vecs[2] = mk(0, 1, corners, corners, 16'd1);
      vecs[3] = mk(0, 0, corners, '0, 16'd1);
      vecs[4] = mk(0, 1, at(7,7), '0, 16'd1);
      vecs[5] = mk(0, 1, at(2,2) | at(2,3) | at(3,2),
                   at(2,2) | at(2,3) | at(3,2) | at(3,3), 16'd1);
      vecs[6] = mk(0, 0, at(0,0) | at(1,0) | at(2,0), at(1,0) | at(1,1), 16'd1);
      vecs[7] = mk(0, 1, at(0,0) | at(1,0) | at(2,0), at(1,11) | at(1,0) | at(1,1), 16'd1);

      repeat (3) tick();
      check("rst_pix", pix_w, '0);
      check("rst_gen", 288'(gen_w), 288'd0);
      check("rst_busy", 288'({busy_w, busy_nw}), 288'd0);
      check("rst_gd", 288'(gd_w), 288'd0);
      reset_btn = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         if (!vecs[i].keep) begin
            clear_board();
            load(vecs[i].init);
         end
         step(n);
         check($sformatf("vec%0d_lat", i), 288'(n), 288'd145);
         check($sformatf("vec%0d_gd_nw", i), 288'(gd_nw), 288'd1);
         tick();
         tick();
         check($sformatf("vec%0d_pix", i), vecs[i].wrap ? pix_w : pix_nw, to_pix(vecs[i].exp));
         check($sformatf("vec%0d_gen", i), 288'(gen_w), 288'(vecs[i].gen));
         check($sformatf("vec%0d_gen_nw", i), 288'(gen_nw), 288'(vecs[i].gen));
      end

      clear_board();
      cursor_row = 4'd3; cursor_col = 4'd4; cursor_en = 1'b1;
      tick();
      tick();
      check("cur_dead", 288'(pix_w[81:80]), 288'(2'b01));
      edit_req = 1'b1;
      tick();
      edit_req = 1'b0;
      tick();
      check("cur_live", 288'(pix_w[81:80]), 288'(2'b10));
      cursor_row = 4'd12; cursor_col = 4'd3; edit_req = 1'b1;
      tick();
      edit_req = 1'b0;
      tick();
      tick();
      check("cur_oob", pix_w, to_pix(at(3,4)));
      cursor_en = 1'b0;

      clear_board();
      load(bh);
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      repeat (50) tick();
      check("busy_scan", 288'(busy_w), 288'd1);
      cursor_row = 4'd7; cursor_col = 4'd4; edit_req = 1'b1; step_req = 1'b1;
      tick();
      edit_req = 1'b0; step_req = 1'b0;
      wait_gen(200, n);
      check("conf_lat", 288'(n + 52), 288'd145);
      tick();
      tick();
      check("conf_pix", pix_w, to_pix(bv));
      check("conf_gen", 288'(gen_w), 288'd1);
      no_gen("conf_nostep", 300);

      clear_board();
      load(bh);
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      repeat (50) tick();
      edit_req = 1'b1; step_req = 1'b1; clear_req = 1'b1;
      tick();
      edit_req = 1'b0; step_req = 1'b0; clear_req = 1'b0;
      wait_gen(200, n);
      check("clrp_lat", 288'(n + 52), 288'd145);
      tick();
      check("clrp_gen1", 288'(gen_w), 288'd1);
      check("clrp_idle", 288'(busy_w), 288'd0);
      tick();
      check("clrp_commit_pix", pix_w, to_pix(bv));
      tick();
      check("clrp_gen0", 288'(gen_w), 288'd0);
      tick();
      check("clrp_pix", pix_w, '0);

      clear_board();
      load(bh);
      run_en = 1'b1;
      wait_gen(400, n);
      check("run_first", 288'(n), 288'd155);
      for (int k = 0; k < 2; k++) begin
         tick();
         wait_gen(400, n);
         check($sformatf("run_period%0d", k), 288'(n + 1), 288'd146);
      end
      tick();
      tick();
      run_en = 1'b0;
      wait_gen(400, n);
      check("run_drop_lat", 288'(n), 288'd144);
      tick();
      check("run_gen", 288'(gen_w), 288'd4);
      tick();
      check("run_pix", pix_w, to_pix(bh));
      no_gen("run_stop", 400);

      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      repeat (60) tick();
      reset_btn = 1'b1;
      #1;
      check("mrst_pix", pix_w, '0);
      check("mrst_gen", 288'(gen_w), 288'd0);
      check("mrst_busy", 288'(busy_w), 288'd0);
      check("mrst_gd", 288'(gd_w), 288'd0);
      tick();
      reset_btn = 1'b0;
      tick();
      tick();
      check("mrst_board", pix_w, '0);
      no_gen("mrst_nogen", 200);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
